// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write path: size codes,
// controller states and the little-endian lane merge.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    // Overlay the narrowed register data onto the old memory word.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] rdata,
        input logic [31:0] wdata,
        input logic [1:0]  byte_off,
        input logic [1:0]  size
    );
        logic [31:0] m;
        m = rdata;
        case (size)
            SZ_BYTE: begin
                case (byte_off)
                    2'd0:    m[7:0]   = wdata[7:0];
                    2'd1:    m[15:8]  = wdata[7:0];
                    2'd2:    m[23:16] = wdata[7:0];
                    default: m[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (byte_off[1]) m[31:16] = wdata[15:0];
                else             m[15:0]  = wdata[15:0];
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

    function automatic logic is_bad_request(
        input logic [1:0] byte_off,
        input logic [1:0] size
    );
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && byte_off[0]) ||
               ((size == SZ_WORD) && (byte_off != 2'b00));
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge of sub-word store data into a fetched memory word.
module store_merge
    import store_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    always_comb begin
        merged = merge_lanes(rdata, wdata, byte_off, size);
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit: word stores write straight through, byte/half stores fetch the
// containing word, merge the new lane(s) and write the full word back.
//
//  state   | meaning
//  IDLE    | waiting for start; request captured and checked here
//  RD      | one-cycle read strobe for the containing word
//  WAIT    | MEM_LAT cycles of read latency, data captured on the last one
//  WR      | one-cycle full-word write (suppressed for errored requests)
//  FIN     | one-cycle done pulse, err reported here
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic [31:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [1:0]    size_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   wbuf_q;
    logic [31:0]   merged;
    logic          bad_req;

    assign bad_req = is_bad_request(addr[1:0], size);

    store_merge u_merge (
        .rdata    (mem_rdata),
        .wdata    ({16'h0000, wdata_q}),
        .byte_off (addr_q[1:0]),
        .size     (size_q),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                addr_q  <= addr;
                wdata_q <= wdata[15:0];
                size_q  <= size;
                err_q   <= bad_req;
                if (size == SZ_WORD && !bad_req) wbuf_q <= wdata;
            end
            if (state_q == ST_RD) begin
                cnt_q <= CNT_LOAD;
            end else if (state_q == ST_WAIT) begin
                if (cnt_q == '0) wbuf_q <= merged;
                else             cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

    // Errored requests pass through WR with the strobe masked so that
    // done lands on the same cycle as a word store.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (bad_req || size == SZ_WORD) state_d = ST_WR;
                    else                            state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0) state_d = ST_WR;
            ST_WR:   state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_re    = (state_q == ST_RD);
        mem_we    = (state_q == ST_WR) && !err_q;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        err       = (state_q == ST_FIN) && err_q;
        mem_addr  = (state_q == ST_IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
        mem_wdata = wbuf_q;
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with a latency-accurate memory read model.
module tb_store_rmw_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start1, start3;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [31:0] mem_val;

    logic [31:0] maddr1, mrdata1, mwdata1, maddr3, mrdata3, mwdata3;
    logic        re1, we1, busy1, done1, err1;
    logic        re3, we3, busy3, done3, err3;

    logic       re_d1 = 1'b0;
    logic [2:0] re_p3 = 3'b000;
    always @(posedge clk) begin
        re_d1 <= re1;
        re_p3 <= {re_p3[1:0], re3};
    end
    assign mrdata1 = re_d1    ? mem_val : 32'hBAD0_BAD0;
    assign mrdata3 = re_p3[2] ? mem_val : 32'hBAD0_BAD0;

    store_rmw_unit #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .addr(addr), .wdata(wdata), .size(size),
        .mem_addr(maddr1), .mem_re(re1), .mem_rdata(mrdata1), .mem_we(we1), .mem_wdata(mwdata1),
        .busy(busy1), .done(done1), .err(err1));

    store_rmw_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .addr(addr), .wdata(wdata), .size(size),
        .mem_addr(maddr3), .mem_re(re3), .mem_rdata(mrdata3), .mem_we(we3), .mem_wdata(mwdata3),
        .busy(busy3), .done(done3), .err(err3));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        int          lat;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rdata;
        int          glitch;
        int          re_cyc;
        int          we_cyc;
        logic [31:0] exp_wdata;
        logic [31:0] exp_maddr;
        int          done_cyc;
        logic        exp_err;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int re_cyc, re_n, we_cyc, we_n, done_cyc, done_n, stray;
        logic [31:0] we_data, we_addr, re_addr;
        logic err_at_done;
        logic s_re, s_we, s_done, s_err;
        logic [31:0] s_addr, s_wd;
        re_cyc = -1; re_n = 0; we_cyc = -1; we_n = 0; done_cyc = -1; done_n = 0; stray = 0;
        we_data = '0; we_addr = '0; re_addr = '0; err_at_done = 1'b0;
        @(posedge clk); #1;
        addr = v.addr; wdata = v.wdata; size = v.size; mem_val = v.rdata;
        if (v.lat == 3) start3 = 1'b1; else start1 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (v.lat == 3) begin
                s_re = re3; s_we = we3; s_done = done3; s_err = err3; s_addr = maddr3; s_wd = mwdata3;
            end else begin
                s_re = re1; s_we = we1; s_done = done1; s_err = err1; s_addr = maddr1; s_wd = mwdata1;
            end
            if (s_re) begin
                if (re_n == 0) begin re_cyc = c; re_addr = s_addr; end
                re_n++;
            end
            if (s_we) begin
                if (we_n == 0) begin we_cyc = c; we_data = s_wd; we_addr = s_addr; end
                we_n++;
            end
            if (s_done) begin
                if (done_n == 0) begin done_cyc = c; err_at_done = s_err; end
                done_n++;
            end else if (s_err) begin
                stray++;
            end
            @(posedge clk); #1;
            start1 = 1'b0; start3 = 1'b0;
            if (c + 1 == v.glitch) begin
                if (v.lat == 3) start3 = 1'b1; else start1 = 1'b1;
            end
        end
        chk({tag, " re_cycle"}, re_cyc, v.re_cyc);
        chk({tag, " re_count"}, re_n, (v.re_cyc >= 0) ? 1 : 0);
        chk({tag, " we_cycle"}, we_cyc, v.we_cyc);
        chk({tag, " we_count"}, we_n, (v.we_cyc >= 0) ? 1 : 0);
        if (v.re_cyc >= 0) chk({tag, " re_addr"}, re_addr, v.exp_maddr);
        if (v.we_cyc >= 0) begin
            chk({tag, " we_data"}, we_data, v.exp_wdata);
            chk({tag, " we_addr"}, we_addr, v.exp_maddr);
        end
        chk({tag, " done_cycle"}, done_cyc, v.done_cyc);
        chk({tag, " done_count"}, done_n, 1);
        chk({tag, " err"}, err_at_done, v.exp_err);
        chk({tag, " err_stray"}, stray, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int we_n, done_n;
        vecs[0] = '{1, 32'h100, 32'hDEADBEEF, 2'b10, 32'h0,        0, -1, 1, 32'hDEADBEEF, 32'h100, 2, 1'b0};
        vecs[1] = '{1, 32'h203, 32'h000000AB, 2'b00, 32'h11223344, 0,  1, 3, 32'hAB223344, 32'h200, 4, 1'b0};
        vecs[2] = '{1, 32'h302, 32'hFFFF5A5A, 2'b01, 32'h11223344, 0,  1, 3, 32'h5A5A3344, 32'h300, 4, 1'b0};
        vecs[3] = '{1, 32'h300, 32'hFFFF5A5A, 2'b01, 32'h11223344, 0,  1, 3, 32'h11225A5A, 32'h300, 4, 1'b0};
        vecs[4] = '{1, 32'h301, 32'h00001234, 2'b01, 32'h11223344, 0, -1, -1, 32'h0,       32'h0,   2, 1'b1};
        vecs[5] = '{1, 32'h302, 32'hCAFEF00D, 2'b10, 32'h11223344, 0, -1, -1, 32'h0,       32'h0,   2, 1'b1};
        vecs[6] = '{1, 32'h100, 32'h00000055, 2'b11, 32'h11223344, 0, -1, -1, 32'h0,       32'h0,   2, 1'b1};
        vecs[7] = '{1, 32'h201, 32'h12345677, 2'b00, 32'hAABBCCDD, 0,  1, 3, 32'hAABB77DD, 32'h200, 4, 1'b0};
        vecs[8] = '{3, 32'h400, 32'h000000C3, 2'b00, 32'h11223344, 3,  1, 5, 32'h112233C3, 32'h400, 6, 1'b0};

        reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        addr = '0; wdata = '0; size = '0; mem_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outputs1", {maddr1, mwdata1, 27'h0, re1, we1, busy1, done1, err1}, '0);
        chk("reset outputs3", {maddr3, mwdata3, 27'h0, re3, we3, busy3, done3, err3}, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while the MEM_LAT=3 unit sits in WAIT: no write may escape.
        @(posedge clk); #1;
        addr = 32'h404; wdata = 32'h99; size = 2'b00; mem_val = 32'h55555555;
        start3 = 1'b1;
        we_n = 0; done_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) chk("rst_mid in_wait", busy3, 1'b1);
            if (c == 3) begin
                chk("rst_mid busy", busy3, 1'b0);
                chk("rst_mid mem_addr", maddr3, 32'h0);
            end
            if (we3) we_n++;
            if (done3) done_n++;
            @(posedge clk); #1;
            start3 = 1'b0;
            reset_n = (c == 1) ? 1'b0 : 1'b1;
        end
        chk("rst_mid we_count", we_n, 0);
        chk("rst_mid done_count", done_n, 0);
        run_vec('{3, 32'h402, 32'h0000BEEF, 2'b01, 32'h55555555, 0, 1, 5, 32'hBEEF5555, 32'h400, 6, 1'b0},
                "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
